// File: rtl/model100_lcd_if.sv
// Signal bundle between the LCD refresh controller, the upstream pixel source and the panel pins.
interface model100_lcd_if;
  logic [7:0] pixels;
  logic [7:0] x;
  logic [3:0] y;
  logic       frame_strobe;
  logic [7:0] data_pin;
  logic [9:0] cs_pin;
  logic       cs1_pin;
  logic       rw_pin;
  logic       di_pin;
  logic       enable_pin;
  logic       reset_pin;

  modport master (
    input  pixels,
    output x, y, frame_strobe, data_pin, cs_pin, cs1_pin, rw_pin, di_pin, enable_pin, reset_pin
  );

  modport slave (
    output pixels,
    input  x, y, frame_strobe, data_pin, cs_pin, cs1_pin, rw_pin, di_pin, enable_pin, reset_pin
  );
endinterface

// File: rtl/model100_lcd.sv
// Continuous refresh of the Model 100 240x64 panel (ten HD44102-style drivers):
// panel reset, one-time driver init, then endless page/column scan of pixel bytes.
module model100_lcd #(
  parameter int unsigned RESET_CYCLES  = 4800,
  parameter int unsigned ENABLE_CYCLES = 24
) (
  input  logic           clk,
  input  logic           reset,
  model100_lcd_if.master lcd
);

  localparam int unsigned RCW = (RESET_CYCLES  > 1) ? $clog2(RESET_CYCLES)  : 1;
  localparam int unsigned TCW = (ENABLE_CYCLES > 1) ? $clog2(ENABLE_CYCLES) : 1;

  typedef enum logic [1:0] {ST_RESET_HOLD, ST_INIT, ST_SCAN} state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_EHIGH, PH_HOLD} phase_t;

  state_t         r_state, w_state_next;
  phase_t         r_phase;
  logic [TCW-1:0] r_tcnt;
  logic [RCW-1:0] r_rcnt;

  logic [3:0] r_ichip;
  logic [1:0] r_icmd;
  logic [3:0] r_chip;
  logic [1:0] r_page;
  logic [5:0] r_col;
  logic       r_is_addr;
  logic       r_frame_end;

  logic [7:0] r_x;
  logic [3:0] r_y;
  logic [7:0] r_data;
  logic [9:0] r_cs;
  logic       r_cs1, r_di, r_en, r_rstn, r_fs;

  logic       w_phase_done, w_slot_free, w_launch, w_di;
  logic [3:0] w_cm;
  logic [7:0] w_base, w_init_cmd, w_data;
  logic [5:0] w_last_col;
  logic [9:0] w_cs;

  assign w_phase_done = (r_tcnt == TCW'(ENABLE_CYCLES - 1));
  assign w_slot_free  = (r_phase == PH_IDLE) || ((r_phase == PH_HOLD) && w_phase_done);
  assign w_cm         = (r_chip >= 4'd5) ? (r_chip - 4'd5) : r_chip;
  assign w_base       = {4'b0000, w_cm} * 8'd50;
  assign w_last_col   = (w_cm == 4'd4) ? 6'd39 : 6'd49;

  always_comb begin
    w_init_cmd = 8'h3E;
    case (r_icmd)
      2'd0:    w_init_cmd = 8'h39;
      2'd1:    w_init_cmd = 8'h3B;
      default: w_init_cmd = 8'h3E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RESET_HOLD;
    else       r_state <= w_state_next;
  end

  // A new write is launched on the last hold cycle of the previous one, so writes run back-to-back.
  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_cs         = '0;
    w_di         = 1'b0;
    w_data       = '0;
    case (r_state)
      ST_RESET_HOLD: begin
        if (r_rcnt == RCW'(RESET_CYCLES - 1)) w_state_next = ST_INIT;
      end
      ST_INIT: begin
        if (w_slot_free) begin
          w_launch = 1'b1;
          w_cs     = 10'd1 << r_ichip;
          w_data   = w_init_cmd;
          if ((r_ichip == 4'd9) && (r_icmd == 2'd2)) w_state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_slot_free) begin
          w_launch = 1'b1;
          w_cs     = 10'd1 << r_chip;
          w_di     = ~r_is_addr;
          w_data   = r_is_addr ? {r_page, 6'b000000} : lcd.pixels;
        end
      end
      default: w_state_next = ST_RESET_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase     <= PH_IDLE;
      r_tcnt      <= '0;
      r_rcnt      <= '0;
      r_ichip     <= '0;
      r_icmd      <= '0;
      r_chip      <= '0;
      r_page      <= '0;
      r_col       <= '0;
      r_is_addr   <= 1'b1;
      r_frame_end <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_data      <= '0;
      r_cs        <= '0;
      r_cs1       <= 1'b0;
      r_di        <= 1'b0;
      r_en        <= 1'b0;
      r_rstn      <= 1'b0;
      r_fs        <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      // Coordinates trail the scan counters by one cycle, well ahead of the next pixel capture.
      r_x  <= w_base + {2'b00, r_col};
      r_y  <= {1'b0, (r_chip >= 4'd5), r_page};

      if (r_state == ST_RESET_HOLD) begin
        r_rcnt <= r_rcnt + 1'b1;
        if (w_state_next == ST_INIT) r_rstn <= 1'b1;
      end

      if (w_launch) begin
        r_cs    <= w_cs;
        r_cs1   <= 1'b1;
        r_di    <= w_di;
        r_data  <= w_data;
        r_en    <= 1'b0;
        r_phase <= PH_SETUP;
        r_tcnt  <= '0;
      end else if (r_phase != PH_IDLE) begin
        if (w_phase_done) begin
          r_tcnt <= '0;
          case (r_phase)
            PH_SETUP: begin r_phase <= PH_EHIGH; r_en <= 1'b1; end
            PH_EHIGH: begin r_phase <= PH_HOLD;  r_en <= 1'b0; end
            default:  begin r_phase <= PH_IDLE;  r_en <= 1'b0; end
          endcase
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end

      if (w_launch && (r_state == ST_INIT)) begin
        if (r_icmd == 2'd2) begin
          r_icmd  <= '0;
          r_ichip <= r_ichip + 1'b1;
        end else begin
          r_icmd <= r_icmd + 1'b1;
        end
      end

      if (w_launch && (r_state == ST_SCAN)) begin
        r_fs        <= r_frame_end;
        r_frame_end <= 1'b0;
        if (r_is_addr) begin
          r_is_addr <= 1'b0;
          r_col     <= '0;
        end else if (r_col == w_last_col) begin
          r_is_addr <= 1'b1;
          r_col     <= '0;
          if (r_page == 2'd3) begin
            r_page <= '0;
            if (r_chip == 4'd9) begin
              r_chip      <= '0;
              r_frame_end <= 1'b1;
            end else begin
              r_chip <= r_chip + 1'b1;
            end
          end else begin
            r_page <= r_page + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign lcd.x            = r_x;
  assign lcd.y            = r_y;
  assign lcd.frame_strobe = r_fs;
  assign lcd.data_pin     = r_data;
  assign lcd.cs_pin       = r_cs;
  assign lcd.cs1_pin      = r_cs1;
  assign lcd.rw_pin       = 1'b0;
  assign lcd.di_pin       = r_di;
  assign lcd.enable_pin   = r_en;
  assign lcd.reset_pin    = r_rstn;

endmodule

// File: tb/tb_model100_lcd.sv
// Directed bench for model100_lcd: reset, init, two full frames with strobe timing, mid-write reset.
module tb_model100_lcd;
  localparam int RC = 10;
  localparam int T  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  int cyc = 0;
  int fs_count = 0, fs_run = 0, fs_maxrun = 0, fs_last = 0, fs_prev = 0;

  model100_lcd_if bus ();

  model100_lcd #(.RESET_CYCLES(RC), .ENABLE_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .lcd   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input logic [7:0] xv, input logic [3:0] yv);
    logic [7:0] y8;
    y8 = {4'h0, yv};
    return (xv * 8'd3 + y8 * 8'd17) ^ 8'hA5;
  endfunction

  always_comb bus.pixels = pix(bus.x, bus.y);

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.frame_strobe === 1'b1) begin
      fs_run++;
      if (fs_run == 1) begin
        fs_prev = fs_last;
        fs_last = cyc;
        fs_count++;
      end
      if (fs_run > fs_maxrun) fs_maxrun = fs_run;
    end else begin
      fs_run = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {bus.x, bus.y, bus.frame_strobe, bus.data_pin, bus.cs_pin, bus.cs1_pin,
                bus.rw_pin, bus.di_pin, bus.enable_pin, bus.reset_pin}, 64'd0);
  endtask

  task automatic release_and_count();
    int n;
    n = 0;
    reset = 1'b0;
    while (bus.reset_pin !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reset_hold_len", n, RC);
  endtask

  task automatic get_write(output logic [28:0] packed_w);
    int n, hi;
    logic ok;
    logic [9:0] cs;
    logic cs1, di;
    logic [7:0] d;
    n = 0;
    hi = 0;
    while (bus.enable_pin !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok  = (bus.enable_pin === 1'b1);
    cs  = bus.cs_pin;
    cs1 = bus.cs1_pin;
    di  = bus.di_pin;
    d   = bus.data_pin;
    while (ok && bus.enable_pin === 1'b1 && hi < 400) begin
      hi++;
      @(negedge clk);
    end
    packed_w = {ok, cs, cs1, di, d, hi[7:0]};
  endtask

  task automatic wr_check(input string tag, input logic [9:0] ecs, input logic edi, input logic [7:0] ed);
    logic [28:0] w;
    logic [7:0]  t8;
    t8 = T;
    get_write(w);
    check(tag, w, {1'b1, ecs, 1'b1, edi, ed, t8});
  endtask

  task automatic init_seq();
    logic [7:0] cmds [3];
    cmds[0] = 8'h39;
    cmds[1] = 8'h3B;
    cmds[2] = 8'h3E;
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < 3; i++)
        wr_check("init", 10'd1 << k, 1'b0, cmds[i]);
  endtask

  task automatic frame(input int idx);
    int ncol;
    logic [7:0] xv;
    logic [3:0] yv;
    logic [1:0] p2;
    for (int k = 0; k < 10; k++) begin
      for (int p = 0; p < 4; p++) begin
        p2 = p[1:0];
        wr_check("addr", 10'd1 << k, 1'b0, {p2, 6'b000000});
        if (k == 0 && p == 0) check("strobes_at_frame_start", fs_count, idx - 1);
        ncol = ((k % 5) == 4) ? 40 : 50;
        for (int c = 0; c < ncol; c++) begin
          xv = 8'(50 * (k % 5) + c);
          yv = 4'(4 * (k / 5) + p);
          wr_check("data", 10'd1 << k, 1'b1, pix(xv, yv));
        end
      end
    end
    check("no_early_strobe", fs_count, idx - 1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_values");

    release_and_count();
    init_seq();

    frame(1);
    frame(2);
    wr_check("frame3_first_addr", 10'd1, 1'b0, 8'h00);
    check("strobe_count", fs_count, 2);
    check("strobe_width", fs_maxrun, 1);
    check("strobe_period", fs_last - fs_prev, 1960 * 3 * T);

    n = 0;
    while (bus.enable_pin !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("mid_write_is_data", {bus.enable_pin, bus.di_pin}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    check("enable_drop_on_reset", bus.enable_pin, 1'b0);
    check_reset_vals("mid_reset_values");
    @(negedge clk);
    release_and_count();
    init_seq();
    wr_check("rescan_addr", 10'd1, 1'b0, 8'h00);
    wr_check("first_data_a5", 10'b0000000001, 1'b1, 8'hA5);
    check("rw_low", bus.rw_pin, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
